// File: rtl/gt_pattern_player.sv
// gt_pattern_player: replays a per-lane pattern RAM onto a multi-lane GT TX stream with loops, backpressure and lane masking.
module gt_pattern_player #(
  parameter int LANES = 6,
  parameter int LANE_W = 32,
  parameter int DEPTH = 256,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LOOP_W = 16
) (
  input  logic                      gt_clk,
  input  logic                      gt_rstb,
  input  logic                      wr_en,
  input  logic [$clog2(LANES)-1:0]  wr_lane,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [LANE_W-1:0]         wr_data,
  input  logic [ADDR_W-1:0]         cfg_len,
  input  logic [LOOP_W-1:0]         cfg_loops,
  input  logic [LANES-1:0]          cfg_lane_mask,
  input  logic                      start,
  input  logic                      stop,
  output logic [LANES*LANE_W-1:0]   m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      busy,
  output logic                      done,
  output logic [LOOP_W-1:0]         loop_cnt,
  output logic                      wr_err
);
  localparam int LW = $clog2(LANES);
  localparam int W = LANES * LANE_W;
  typedef enum logic [1:0] {IDLE, PLAY, FIN} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] len_r, ptr_r, len, ptr;
  logic [LOOP_W-1:0] loops_r, icnt_r, loops, icnt;
  logic [LANES-1:0] mask_r;
  logic fin_r, go, abort, issue, last, rd_vld, rd_last, pop, push, fin_word;
  logic [1:0] q_cnt, q_cnt_s;
  logic [W:0] q0, q1, din;
  logic [W-1:0] rd_data;
  assign go = state != PLAY && start && !stop;
  assign abort = state == PLAY && stop;
  assign len = go ? cfg_len : len_r;
  assign loops = go ? cfg_loops : loops_r;
  assign ptr = go ? '0 : ptr_r;
  assign icnt = go ? '0 : icnt_r;
  assign pop = m_valid && m_ready;
  assign push = rd_vld;
  // Only read when the word in flight plus the queue still fit in the 2-entry output queue.
  assign issue = go || (state == PLAY && !stop && !fin_r &&
                 q_cnt + {1'b0, rd_vld} <= {1'b0, pop} + 2'd1);
  assign last = ptr == len;
  assign fin_word = state == PLAY && pop && q0[W] && loops_r != '0 &&
                    loop_cnt + LOOP_W'(1) == loops_r;
  assign q_cnt_s = q_cnt - {1'b0, pop};
  assign din = {rd_last, rd_data};
  assign m_valid = q_cnt != 2'd0;
  assign m_data = q0[W-1:0];
  assign busy = state == PLAY;
  assign done = state == FIN;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [LANE_W-1:0] mem [DEPTH];
    logic [LANE_W-1:0] rd_q;
    always_ff @(posedge gt_clk) begin
      if (wr_en && !busy && wr_lane == LW'(l)) mem[wr_addr] <= wr_data;
      if (issue) rd_q <= mem[ptr];
    end
    assign rd_data[l*LANE_W +: LANE_W] = mask_r[l] ? rd_q : '0;
  end
  always_comb begin
    state_n = state == PLAY ? (stop ? IDLE : fin_word ? FIN : PLAY) : go ? PLAY : IDLE;
  end
  always_ff @(posedge gt_clk) begin
    if (!gt_rstb) begin
      state <= IDLE;
      q_cnt <= '0;
      q0 <= '0;
      q1 <= '0;
      rd_vld <= 1'b0;
      rd_last <= 1'b0;
      loop_cnt <= '0;
      wr_err <= 1'b0;
      ptr_r <= '0;
      icnt_r <= '0;
      fin_r <= 1'b0;
      len_r <= '0;
      loops_r <= '0;
      mask_r <= '0;
    end else begin
      state <= state_n;
      rd_vld <= issue;
      if (issue) begin
        ptr_r <= last ? '0 : ptr + ADDR_W'(1);
        icnt_r <= icnt + LOOP_W'(last);
        fin_r <= last && loops != '0 && icnt + LOOP_W'(1) == loops;
        rd_last <= last;
      end
      if (go) begin
        len_r <= cfg_len;
        loops_r <= cfg_loops;
        mask_r <= cfg_lane_mask;
      end
      loop_cnt <= go ? '0 : loop_cnt + LOOP_W'(pop && q0[W]);
      wr_err <= !go && (wr_err || (wr_en && busy));
      q_cnt <= abort ? '0 : q_cnt_s + {1'b0, push};
      q0 <= push && q_cnt_s == 2'd0 ? din : pop ? q1 : q0;
      q1 <= push && q_cnt_s == 2'd1 ? din : q1;
    end
  end
endmodule

// File: tb/tb_gt_pattern_player.sv
// tb_gt_pattern_player: directed scenario tests for gt_pattern_player with a bench-side RAM model.
module tb_gt_pattern_player;
  logic gt_clk = 0, gt_rstb = 0, wr_en = 0, start = 0, stop = 0, m_ready = 0;
  logic [2:0] wr_lane = 0;
  logic [7:0] wr_addr = 0, cfg_len = 0;
  logic [31:0] wr_data = 0;
  logic [15:0] cfg_loops = 0, loop_cnt;
  logic [5:0] cfg_lane_mask = 0;
  logic [191:0] m_data;
  logic m_valid, busy, done, wr_err;
  int total = 0, bad = 0;
  logic [31:0] exp_mem [6][256];
  logic [191:0] got[$];
  int first_lat, done_cyc, last_acc, unstable;
  logic busy_done;
  logic [15:0] lc_done;

  gt_pattern_player dut (
    .gt_clk(gt_clk), .gt_rstb(gt_rstb), .wr_en(wr_en), .wr_lane(wr_lane), .wr_addr(wr_addr),
    .wr_data(wr_data), .cfg_len(cfg_len), .cfg_loops(cfg_loops), .cfg_lane_mask(cfg_lane_mask),
    .start(start), .stop(stop), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .loop_cnt(loop_cnt), .wr_err(wr_err)
  );

  always #5 gt_clk = ~gt_clk;

  function automatic logic [191:0] exp_word(int a, logic [5:0] mk);
    logic [191:0] w;
    w = '0;
    for (int l = 0; l < 6; l++) if (mk[l]) w[l*32 +: 32] = exp_mem[l][a];
    return w;
  endfunction

  task automatic wr(input logic [2:0] l, input logic [7:0] a, input logic [31:0] d);
    wr_en = 1; wr_lane = l; wr_addr = a; wr_data = d;
    @(negedge gt_clk);
    wr_en = 0;
  endtask

  // Starts a run, scrambles the config afterwards, and records accepted words and timing.
  task automatic play(input logic [7:0] len, input logic [15:0] loops, input logic [5:0] mk,
                      input bit rnd, input int limit);
    logic [191:0] hd;
    bit held;
    got.delete(); first_lat = -1; done_cyc = -1; last_acc = -1; unstable = 0; held = 0;
    hd = '0; busy_done = 1'bx; lc_done = 'x;
    cfg_len = len; cfg_loops = loops; cfg_lane_mask = mk; start = 1; m_ready = 1;
    for (int c = 1; c <= limit && done_cyc < 0; c++) begin
      @(negedge gt_clk);
      start = 0; cfg_len = ~len; cfg_loops = loops + 16'd5; cfg_lane_mask = ~mk;
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held && (m_valid !== 1'b1 || m_data !== hd)) unstable++;
      if (m_valid === 1'b1 && first_lat < 0) first_lat = c;
      if (done === 1'b1) begin done_cyc = c; busy_done = busy; lc_done = loop_cnt; end
      held = m_valid === 1'b1 && !m_ready;
      hd = m_data;
      if (m_valid === 1'b1 && m_ready) begin got.push_back(m_data); last_acc = c; end
    end
  endtask

  task automatic test_reset;
    gt_rstb = 0;
    repeat (3) @(negedge gt_clk);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
    total++; if (m_data !== '0) begin bad++; $display("FAIL reset_m_data got=%h want=0", m_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (loop_cnt !== 16'd0) begin bad++; $display("FAIL reset_loop_cnt got=%0d want=0", loop_cnt); end
    total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL reset_wr_err got=%b want=0", wr_err); end
    gt_rstb = 1;
    @(negedge gt_clk);
  endtask

  task automatic fill;
    logic [31:0] d;
    for (int a = 0; a < 20; a++)
      for (int l = 0; l < 6; l++) begin
        d = $urandom;
        exp_mem[l][a] = d;
        wr(3'(l), 8'(a), d);
      end
    wr(3'd6, 8'd0, 32'hFFFF_FFFF);
  endtask

  task automatic test_basic;
    play(8'd19, 16'd2, 6'h3F, 0, 100);
    total++; if (got.size() != 40) begin bad++; $display("FAIL basic_count got=%0d want=40", got.size()); end
    total++; if (first_lat != 2) begin bad++; $display("FAIL basic_latency got=%0d want=2", first_lat); end
    total++; if (last_acc != 41) begin bad++; $display("FAIL basic_contiguous last_word_cycle=%0d want=41", last_acc); end
    total++; if (done_cyc != 42) begin bad++; $display("FAIL basic_done_cycle got=%0d want=42", done_cyc); end
    total++; if (busy_done !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b want=0", busy_done); end
    total++; if (lc_done !== 16'd2) begin bad++; $display("FAIL basic_loop_cnt got=%0d want=2", lc_done); end
    for (int i = 0; i < 40 && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_word(i % 20, 6'h3F)) begin
        bad++; $display("FAIL basic_word[%0d] got=%h want=%h", i, got[i], exp_word(i % 20, 6'h3F));
      end
    end
  endtask

  task automatic test_backpressure;
    play(8'd19, 16'd2, 6'h3F, 1, 400);
    total++; if (got.size() != 40) begin bad++; $display("FAIL bp_count got=%0d want=40", got.size()); end
    total++; if (first_lat != 2) begin bad++; $display("FAIL bp_latency got=%0d want=2", first_lat); end
    total++; if (unstable != 0) begin bad++; $display("FAIL bp_stable unstable_stalls=%0d want=0", unstable); end
    total++; if (done_cyc != last_acc + 1) begin bad++; $display("FAIL bp_done_cycle got=%0d want=%0d", done_cyc, last_acc + 1); end
    total++; if (lc_done !== 16'd2) begin bad++; $display("FAIL bp_loop_cnt got=%0d want=2", lc_done); end
    for (int i = 0; i < 40 && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_word(i % 20, 6'h3F)) begin
        bad++; $display("FAIL bp_word[%0d] got=%h want=%h", i, got[i], exp_word(i % 20, 6'h3F));
      end
    end
  endtask

  task automatic test_mask;
    play(8'd19, 16'd1, 6'b101010, 0, 100);
    total++; if (got.size() != 20) begin bad++; $display("FAIL mask_count got=%0d want=20", got.size()); end
    for (int i = 0; i < 20 && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_word(i, 6'b101010)) begin
        bad++; $display("FAIL mask_word[%0d] got=%h want=%h", i, got[i], exp_word(i, 6'b101010));
      end
    end
  endtask

  task automatic test_len0;
    play(8'd0, 16'd3, 6'h3F, 0, 50);
    total++; if (got.size() != 3) begin bad++; $display("FAIL len0_count got=%0d want=3", got.size()); end
    total++; if (done_cyc != 5) begin bad++; $display("FAIL len0_done_cycle got=%0d want=5", done_cyc); end
    total++; if (lc_done !== 16'd3) begin bad++; $display("FAIL len0_loop_cnt got=%0d want=3", lc_done); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_word(0, 6'h3F)) begin
        bad++; $display("FAIL len0_word[%0d] got=%h want=%h", i, got[i], exp_word(0, 6'h3F));
      end
    end
  endtask

  task automatic test_stop;
    int n, d;
    n = 0; d = 0;
    cfg_len = 8'd4; cfg_loops = 16'd0; cfg_lane_mask = 6'h3F; start = 1; m_ready = 1;
    for (int c = 0; c < 100 && n < 23; c++) begin
      @(negedge gt_clk);
      start = 0;
      if (m_valid === 1'b1 && m_ready) n++;
    end
    @(negedge gt_clk);
    stop = 1; m_ready = 0;
    @(negedge gt_clk);
    stop = 0; m_ready = 1;
    total++; if (n != 23) begin bad++; $display("FAIL stop_accepted got=%0d want=23", n); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL stop_m_valid got=%b want=0", m_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_busy got=%b want=0", busy); end
    total++; if (loop_cnt !== 16'd4) begin bad++; $display("FAIL stop_loop_cnt got=%0d want=4", loop_cnt); end
    for (int c = 0; c < 5; c++) begin
      if (done !== 1'b0 || m_valid !== 1'b0) d++;
      @(negedge gt_clk);
    end
    total++; if (d != 0) begin bad++; $display("FAIL stop_no_done cycles_with_done_or_valid=%0d want=0", d); end
  endtask

  task automatic test_wr_busy;
    cfg_len = 8'd19; cfg_loops = 16'd1; cfg_lane_mask = 6'h3F; start = 1; m_ready = 1;
    @(negedge gt_clk);
    start = 0;
    @(negedge gt_clk);
    wr(3'd2, 8'd3, 32'hDEAD_BEEF);
    total++; if (wr_err !== 1'b1) begin bad++; $display("FAIL wrbusy_err_set got=%b want=1", wr_err); end
    for (int c = 0; c < 100 && done !== 1'b1; c++) @(negedge gt_clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL wrbusy_done got=%b want=1", done); end
    total++; if (wr_err !== 1'b1) begin bad++; $display("FAIL wrbusy_err_sticky got=%b want=1", wr_err); end
    play(8'd3, 16'd1, 6'h3F, 0, 50);
    total++; if (first_lat != 2) begin bad++; $display("FAIL b2b_latency got=%0d want=2", first_lat); end
    total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL wrbusy_err_clear got=%b want=0", wr_err); end
    total++; if (got.size() != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", got.size()); end
    total++; if (got[3] !== exp_word(3, 6'h3F)) begin bad++; $display("FAIL wrbusy_ram got=%h want=%h", got[3], exp_word(3, 6'h3F)); end
  endtask

  task automatic test_start_stop;
    int d;
    d = 0;
    cfg_len = 8'd3; cfg_loops = 16'd1; cfg_lane_mask = 6'h3F; start = 1; stop = 1;
    @(negedge gt_clk);
    start = 0; stop = 0;
    for (int c = 0; c < 4; c++) begin
      if (m_valid !== 1'b0 || busy !== 1'b0) d++;
      @(negedge gt_clk);
    end
    total++; if (d != 0) begin bad++; $display("FAIL startstop_idle active_cycles=%0d want=0", d); end
  endtask

  task automatic test_reset_mid;
    cfg_len = 8'd0; cfg_loops = 16'd0; cfg_lane_mask = 6'h3F; start = 1; m_ready = 1;
    @(negedge gt_clk);
    start = 0;
    repeat (4) @(negedge gt_clk);
    wr(3'd1, 8'd5, 32'h1234_5678);
    repeat (3) @(negedge gt_clk);
    total++; if (m_valid !== 1'b1 || wr_err !== 1'b1 || loop_cnt == 16'd0) begin
      bad++; $display("FAIL midrst_pre valid=%b err=%b loop_cnt=%0d want=1,1,nonzero", m_valid, wr_err, loop_cnt);
    end
    gt_rstb = 0;
    @(negedge gt_clk);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL midrst_m_valid got=%b want=0", m_valid); end
    total++; if (m_data !== '0) begin bad++; $display("FAIL midrst_m_data got=%h want=0", m_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
    total++; if (loop_cnt !== 16'd0) begin bad++; $display("FAIL midrst_loop_cnt got=%0d want=0", loop_cnt); end
    total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL midrst_wr_err got=%b want=0", wr_err); end
    gt_rstb = 1;
    @(negedge gt_clk);
  endtask

  initial begin
    test_reset;
    fill;
    test_basic;
    test_backpressure;
    test_mask;
    test_len0;
    test_stop;
    test_wr_busy;
    test_start_stop;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
